noc_xbar_rr_allocator: RTL and testbench

//  Switch allocator for NOC_CrossBar. It looks at the head-of-line flit of each input FIFO
//  and picks at most one input per output port, using a round-robin pointer per output.
//  It pops the winning input FIFOs, then drives registered crossbar selects and

---
 rtl/noc_xbar_rr_allocator.sv | 85 ++++++++
 tb/tb_noc_xbar_rr_allocator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/noc_xbar_rr_allocator.sv
// Crossbar switch allocator: per-output round-robin arbitration over input FIFO heads,
// combinational pops, and a registered select/enqueue stage one cycle behind the grant.
module noc_xbar_rr_allocator #(
    parameter int RADIX_IN   = 4,
    parameter int RADIX_OUT  = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int SEL_WIDTH  = $clog2(RADIX_IN)
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           alloc_en,
    input  logic [RADIX_IN-1:0]            req_valid,
    input  logic [RADIX_IN*ADDR_WIDTH-1:0] req_dest,
    input  logic [RADIX_OUT-1:0]           FIFO_FULL_downstream,
    output logic [RADIX_IN-1:0]            deq,
    output logic [RADIX_OUT-1:0]           out_valid,
    output logic [RADIX_OUT*SEL_WIDTH-1:0] out_sel,
    output logic                           drop_err
);

    // Handshake: deq[i] pops input FIFO i in the same cycle it is high; out_valid[o] is a
    // one-cycle enqueue strobe for output o, only issued while that output was not full.
    logic [SEL_WIDTH-1:0] ptr     [RADIX_OUT];
    logic [RADIX_IN-1:0]  gnt     [RADIX_OUT];
    logic [SEL_WIDTH-1:0] win     [RADIX_OUT];
    logic [RADIX_OUT-1:0] granted;
    logic [RADIX_IN-1:0]  drop_req;
    logic [RADIX_IN-1:0]  deq_raw;
    logic [SEL_WIDTH-1:0] cand;

    function automatic logic [31:0] dest_of(input logic [RADIX_IN*ADDR_WIDTH-1:0] dests,
                                            input int idx);
        return 32'(dests[idx*ADDR_WIDTH +: ADDR_WIDTH]);
    endfunction

    always_comb begin
        cand     = '0;
        granted  = '0;
        for (int i = 0; i < RADIX_IN; i++) begin
            drop_req[i] = alloc_en && req_valid[i] &&
                          (dest_of(req_dest, i) >= 32'(RADIX_OUT));
        end
        deq_raw = drop_req;
        for (int o = 0; o < RADIX_OUT; o++) begin
            gnt[o] = '0;
            win[o] = '0;
            if (alloc_en && !FIFO_FULL_downstream[o]) begin
                // Scan starting at the pointer; the first requester found wins.
                for (int k = 0; k < RADIX_IN; k++) begin
                    cand = SEL_WIDTH'((int'(ptr[o]) + k) % RADIX_IN);
                    if (!granted[o] && req_valid[cand] &&
                        dest_of(req_dest, int'(cand)) == 32'(o)) begin
                        gnt[o][cand] = 1'b1;
                        win[o]       = cand;
                        granted[o]   = 1'b1;
                    end
                end
            end
            deq_raw = deq_raw | gnt[o];
        end
    end

    assign deq = rst_l ? deq_raw : '0;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_valid <= '0;
            out_sel   <= '0;
            drop_err  <= 1'b0;
            for (int o = 0; o < RADIX_OUT; o++) begin
                ptr[o] <= '0;
            end
        end else begin
            drop_err <= |drop_req;
            for (int o = 0; o < RADIX_OUT; o++) begin
                out_valid[o] <= granted[o];
                if (granted[o]) begin
                    out_sel[o*SEL_WIDTH +: SEL_WIDTH] <= win[o];
                    ptr[o] <= SEL_WIDTH'((int'(win[o]) + 1) % RADIX_IN);
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_xbar_rr_allocator.sv
// Directed bench for noc_xbar_rr_allocator: a 4x4 instance for arbitration, back-pressure
// and reset, plus a 4x3 instance for out-of-range destination drops.
module tb_noc_xbar_rr_allocator;

    logic       clk;
    logic       rst_l;
    logic       alloc_en;
    logic [3:0] req_valid;
    logic [7:0] req_dest;
    logic [3:0] full;
    logic [3:0] deq;
    logic [3:0] out_valid;
    logic [7:0] out_sel;
    logic       drop_err;

    logic [3:0] req_valid3;
    logic [7:0] req_dest3;
    logic [2:0] full3;
    logic [3:0] deq3;
    logic [2:0] out_valid3;
    logic [5:0] out_sel3;
    logic       drop_err3;

    logic [12:0] exp_q[$];
    logic [9:0]  exp3_q[$];
    int checks;
    int failures;

    noc_xbar_rr_allocator #(.RADIX_IN(4), .RADIX_OUT(4), .ADDR_WIDTH(2)) dut (
        .clk(clk), .rst_l(rst_l), .alloc_en(alloc_en), .req_valid(req_valid),
        .req_dest(req_dest), .FIFO_FULL_downstream(full), .deq(deq),
        .out_valid(out_valid), .out_sel(out_sel), .drop_err(drop_err)
    );

    noc_xbar_rr_allocator #(.RADIX_IN(4), .RADIX_OUT(3), .ADDR_WIDTH(2)) dut3 (
        .clk(clk), .rst_l(rst_l), .alloc_en(alloc_en), .req_valid(req_valid3),
        .req_dest(req_dest3), .FIFO_FULL_downstream(full3), .deq(deq3),
        .out_valid(out_valid3), .out_sel(out_sel3), .drop_err(drop_err3)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks: inputs change on the falling edge, deq is checked 1ns later
    task automatic drive(input logic en, input logic [3:0] v, input logic [7:0] d,
                         input logic [3:0] f, input logic [3:0] e_deq,
                         input logic [3:0] e_ov, input logic [7:0] e_sel, input string name);
        @(negedge clk);
        alloc_en   = en;
        req_valid  = v;
        req_dest   = d;
        full       = f;
        req_valid3 = '0;
        #1;
        check({name, " deq"}, 32'(deq), 32'(e_deq));
        exp_q.push_back({e_ov, e_sel, 1'b0});
    endtask

    task automatic drive3(input logic en, input logic [3:0] v, input logic [7:0] d,
                          input logic [3:0] e_deq, input logic [2:0] e_ov,
                          input logic [5:0] e_sel, input logic e_drop, input string name);
        @(negedge clk);
        alloc_en   = en;
        req_valid  = '0;
        req_valid3 = v;
        req_dest3  = d;
        #1;
        check({name, " deq3"}, 32'(deq3), 32'(e_deq));
        exp3_q.push_back({e_ov, e_sel, e_drop});
    endtask

    // scoreboard monitor: pops one expectation per edge for each instance that has one
    initial begin
        logic [12:0] e;
        logic [9:0]  e3;
        logic [3:0]  full_at_edge;
        forever begin
            @(posedge clk);
            full_at_edge = full;
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out {valid,sel,drop}", 32'({out_valid, out_sel, drop_err}), 32'(e));
            end
            if (exp3_q.size() > 0) begin
                e3 = exp3_q.pop_front();
                check("out3 {valid,sel,drop}", 32'({out_valid3, out_sel3, drop_err3}), 32'(e3));
            end
            if (full_at_edge != '0)
                check("enq while full", 32'(out_valid & full_at_edge), 32'(0));
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst_l      = 1'b0;
        alloc_en   = 1'b0;
        req_valid  = '0;
        req_dest   = '0;
        full       = '0;
        req_valid3 = '0;
        req_dest3  = '0;
        full3      = '0;
        #2;
        check("reset out_valid", 32'(out_valid), 32'(0));
        check("reset out_sel", 32'(out_sel), 32'(0));
        check("reset drop_err", 32'(drop_err), 32'(0));
        check("reset deq", 32'(deq), 32'(0));
        check("reset dut3 outs", 32'({out_valid3, out_sel3, drop_err3, deq3}), 32'(0));
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        // idle after reset
        drive(1, 4'b0000, 8'h00, 4'h0, 4'b0000, 4'b0000, 8'h00, "idle0");
        drive(1, 4'b0000, 8'h00, 4'h0, 4'b0000, 4'b0000, 8'h00, "idle1");

        // all inputs to output 0: grant order 0,1,2,3,0
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0001, 4'b0001, 8'h00, "rr0");
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0010, 4'b0001, 8'h01, "rr1");
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0100, 4'b0001, 8'h02, "rr2");
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b1000, 4'b0001, 8'h03, "rr3");
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0001, 4'b0001, 8'h00, "rr4");
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0010, 4'b0001, 8'h01, "rr5");

        // asynchronous reset mid-stream, between edges
        @(posedge clk);
        #3;
        rst_l = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'(0));
        check("midrst out_sel", 32'(out_sel), 32'(0));
        check("midrst drop_err", 32'(drop_err), 32'(0));
        check("midrst deq", 32'(deq), 32'(0));
        @(negedge clk);
        req_valid = '0;
        rst_l     = 1'b1;
        drive(1, 4'b1111, 8'h00, 4'h0, 4'b0001, 4'b0001, 8'h00, "restart");

        // one input per output, all granted together
        drive(1, 4'b1111, 8'h1B, 4'h0, 4'b1111, 4'b1111, 8'h1B, "parallel");

        // inputs 1,2 to output 1 while output 1 is full, then released
        drive(1, 4'b0110, 8'h14, 4'b0010, 4'b0000, 4'b0000, 8'h1B, "full0");
        drive(1, 4'b0110, 8'h14, 4'b0010, 4'b0000, 4'b0000, 8'h1B, "full1");
        drive(1, 4'b0110, 8'h14, 4'b0010, 4'b0000, 4'b0000, 8'h1B, "full2");
        drive(1, 4'b0110, 8'h14, 4'b0000, 4'b0010, 4'b0010, 8'h17, "unfull0");
        drive(1, 4'b0110, 8'h14, 4'b0000, 4'b0100, 4'b0010, 8'h1B, "unfull1");

        // full on output 1 must not block output 0
        drive(1, 4'b1001, 8'h01, 4'b0010, 4'b1000, 4'b0001, 8'h1B, "indep");

        // alloc_en low: no pops, outputs deassert, selects hold
        drive(0, 4'b1111, 8'h1B, 4'h0, 4'b0000, 4'b0000, 8'h1B, "noalloc");
        drive(1, 4'b1111, 8'h1B, 4'h0, 4'b1111, 4'b1111, 8'h1B, "realloc");

        // out-of-range destination on the 3-output instance
        drive3(0, 4'b0100, 8'h30, 4'b0000, 3'b000, 6'h00, 1'b0, "drop_noalloc");
        drive3(1, 4'b0100, 8'h30, 4'b0100, 3'b000, 6'h00, 1'b1, "drop");
        drive3(1, 4'b1001, 8'h00, 4'b0001, 3'b001, 6'h00, 1'b0, "after_drop0");
        drive3(1, 4'b1001, 8'h00, 4'b1000, 3'b001, 6'h03, 1'b0, "after_drop1");
        drive3(1, 4'b0000, 8'h00, 4'b0000, 3'b000, 6'h03, 1'b0, "idle3");

        repeat (3) @(negedge clk);
        check("exp_q drained", 32'(exp_q.size()), 32'(0));
        check("exp3_q drained", 32'(exp3_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
